// File: rtl/noc_iob_bridge_pkg.sv
// Shared definitions for the NoC <-> I/O block bridge: header field
// positions, message types, inbound FSM states and tile addressing helpers.
package noc_iob_bridge_pkg;

    localparam int DST_Y_LSB = 56;
    localparam int DST_X_LSB = 48;
    localparam int LEN_LSB   = 22;
    localparam int TYPE_LSB  = 14;
    localparam int FIELD_W   = 8;

    localparam logic [7:0] MSG_TYPE_INTERRUPT = 8'h0A;

    typedef enum logic [1:0] {IDLE, BODY, FULL} in_state_e;

    // Column of a linear tile id in an x_tiles-wide grid.
    function automatic logic [7:0] tile_x(input logic [31:0] tile, input int x_tiles);
        logic [31:0] r;
        r = tile % 32'(x_tiles);
        return r[7:0];
    endfunction

    // Row of a linear tile id in an x_tiles-wide grid.
    function automatic logic [7:0] tile_y(input logic [31:0] tile, input int x_tiles);
        logic [31:0] q;
        q = tile / 32'(x_tiles);
        return q[7:0];
    endfunction

    // 64-bit header with every non-field bit zero.
    function automatic logic [63:0] make_hdr(input logic [7:0] dst_y, input logic [7:0] dst_x,
                                             input logic [7:0] len, input logic [7:0] typ);
        logic [63:0] h;
        h = '0;
        h[DST_Y_LSB +: FIELD_W] = dst_y;
        h[DST_X_LSB +: FIELD_W] = dst_x;
        h[LEN_LSB   +: FIELD_W] = len;
        h[TYPE_LSB  +: FIELD_W] = typ;
        return h;
    endfunction

endpackage

// File: rtl/noc_iob_out_fifo.sv
// Outbound flit FIFO: up to two writes and one read per cycle, head shown
// combinationally (zero when empty).
module noc_iob_out_fifo #(
    parameter int FLIT_W    = 64,
    parameter int OUT_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push2,
    input  logic [FLIT_W-1:0]            wdata0,
    input  logic [FLIT_W-1:0]            wdata1,
    input  logic                         pop,
    output logic [FLIT_W-1:0]            rdata,
    output logic [$clog2(OUT_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    // Local guards keep the FIFO safe even if a caller misbehaves.
    assign do_push = push2 && (count <= CNT_W'(OUT_DEPTH - 2));
    assign do_pop  = pop && (count != '0);
    assign rdata   = (count != '0) ? mem[rd_ptr] : '0;

    // Storage writes; pointers wrap naturally since OUT_DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr]               <= wdata0;
            mem[wr_ptr + PTR_W'(1)]   <= wdata1;
        end
    end

    // Pointer and occupancy update; push-2 with pop-1 nets +1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(2);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (do_push ? CNT_W'(2) : CNT_W'(0)) - (do_pop ? CNT_W'(1) : CNT_W'(0));
        end
    end

endmodule

// File: rtl/noc_iob_bridge.sv
// NoC <-> I/O block bridge: assembles inbound NoC packets into a wide request
// and turns interrupt requests into two-flit outbound NoC messages.
module noc_iob_bridge
    import noc_iob_bridge_pkg::*;
#(
    parameter int FLIT_W    = 64,
    parameter int MAX_FLITS = 4,
    parameter int OUT_DEPTH = 8,
    parameter int X_TILES   = 8,
    parameter int Y_TILES   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          noc_in_val,
    output logic                          noc_in_rdy,
    input  logic [FLIT_W-1:0]             noc_in_data,
    output logic                          req_val,
    input  logic                          req_rdy,
    output logic [$clog2(MAX_FLITS):0]    req_len,
    output logic [MAX_FLITS*FLIT_W-1:0]   req_data,
    input  logic                          intr_val,
    output logic                          intr_rdy,
    input  logic [31:0]                   intr_tile,
    input  logic [63:0]                   intr_data,
    output logic                          noc_out_val,
    input  logic                          noc_out_rdy,
    output logic [FLIT_W-1:0]             noc_out_data,
    output logic [$clog2(OUT_DEPTH):0]    out_count,
    output logic                          err_oversize,
    output logic                          err_bad_tile
);
    localparam int NUM_TILES = X_TILES * Y_TILES;
    localparam int LEN_W     = $clog2(MAX_FLITS) + 1;
    localparam int CNT_W     = $clog2(OUT_DEPTH) + 1;

    in_state_e         state_q, state_d;
    logic [FLIT_W-1:0] slot_q [MAX_FLITS];
    logic [LEN_W-1:0]  stored_q;
    logic [7:0]        body_left_q;
    logic [7:0]        hdr_len;
    logic              in_xfer, intr_xfer, tile_ok, push2;
    logic [FLIT_W-1:0] intr_flit0, intr_flit1;
    logic              unused_intr_bits;

    // Outputs forced to their idle values while reset is asserted.
    assign noc_in_rdy  = !rst_n || (state_q != FULL);
    assign req_val     = rst_n && (state_q == FULL);
    assign req_len     = stored_q;
    assign in_xfer     = noc_in_val && noc_in_rdy;
    assign hdr_len     = noc_in_data[LEN_LSB +: FIELD_W];

    // Header at the top slot, unused slots already zero.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < MAX_FLITS; i++)
            req_data[(MAX_FLITS-1-i)*FLIT_W +: FLIT_W] = slot_q[i];
    end

    // Inbound FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Inbound FSM next state: FULL only after every announced body flit arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_xfer) state_d = (hdr_len == '0) ? FULL : BODY;
            BODY:    if (in_xfer && body_left_q == 8'd1) state_d = FULL;
            FULL:    if (req_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packet slots and counters; flits past the last slot are consumed but dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_FLITS; i++) slot_q[i] <= '0;
            stored_q     <= '0;
            body_left_q  <= '0;
            err_oversize <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_xfer) begin
                    for (int i = 0; i < MAX_FLITS; i++) slot_q[i] <= (i == 0) ? noc_in_data : '0;
                    stored_q    <= LEN_W'(1);
                    body_left_q <= hdr_len;
                    if (hdr_len > 8'(MAX_FLITS - 1)) err_oversize <= 1'b1;
                end
                BODY: if (in_xfer) begin
                    if (stored_q < LEN_W'(MAX_FLITS)) begin
                        for (int i = 0; i < MAX_FLITS; i++)
                            if (LEN_W'(i) == stored_q) slot_q[i] <= noc_in_data;
                        stored_q <= stored_q + LEN_W'(1);
                    end
                    body_left_q <= body_left_q - 8'd1;
                end
                FULL: if (req_rdy) begin
                    for (int i = 0; i < MAX_FLITS; i++) slot_q[i] <= '0;
                    stored_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Interrupt side: accept only with room for both flits; bad tiles are dropped.
    assign intr_rdy   = !rst_n || (out_count <= CNT_W'(OUT_DEPTH - 2));
    assign intr_xfer  = rst_n && intr_val && intr_rdy;
    assign tile_ok    = intr_tile < 32'(NUM_TILES);
    assign push2      = intr_xfer && tile_ok;
    assign intr_flit0 = FLIT_W'(make_hdr(tile_y(intr_tile, X_TILES), tile_x(intr_tile, X_TILES),
                                         8'd1, MSG_TYPE_INTERRUPT));
    assign intr_flit1 = FLIT_W'({intr_data[63:16], 7'b0, intr_data[8:0]});
    assign unused_intr_bits = ^intr_data[15:9];

    // Sticky bad-tile flag.
    always_ff @(posedge clk) begin
        if (!rst_n)                    err_bad_tile <= 1'b0;
        else if (intr_xfer && !tile_ok) err_bad_tile <= 1'b1;
    end

    assign noc_out_val = rst_n && (out_count != '0);

    noc_iob_out_fifo #(
        .FLIT_W    (FLIT_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push2  (push2),
        .wdata0 (intr_flit0),
        .wdata1 (intr_flit1),
        .pop    (noc_out_val && noc_out_rdy),
        .rdata  (noc_out_data),
        .count  (out_count)
    );

endmodule

// File: tb/tb_noc_iob_bridge.sv
// Self-checking bench for noc_iob_bridge (default parameters: 64-bit flits,
// 4 slots, 8-entry FIFO, 8x8 grid). Inputs change and outputs are observed
// on the falling clock edge.
module tb_noc_iob_bridge;
    localparam int FW = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             noc_in_val, noc_in_rdy;
    logic [FW-1:0]    noc_in_data;
    logic             req_val, req_rdy;
    logic [2:0]       req_len;
    logic [4*FW-1:0]  req_data;
    logic             intr_val, intr_rdy;
    logic [31:0]      intr_tile;
    logic [63:0]      intr_data;
    logic             noc_out_val, noc_out_rdy;
    logic [FW-1:0]    noc_out_data;
    logic [3:0]       out_count;
    logic             err_oversize, err_bad_tile;

    int checks = 0;
    int errors = 0;

    noc_iob_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .noc_in_val(noc_in_val), .noc_in_rdy(noc_in_rdy), .noc_in_data(noc_in_data),
        .req_val(req_val), .req_rdy(req_rdy), .req_len(req_len), .req_data(req_data),
        .intr_val(intr_val), .intr_rdy(intr_rdy), .intr_tile(intr_tile), .intr_data(intr_data),
        .noc_out_val(noc_out_val), .noc_out_rdy(noc_out_rdy), .noc_out_data(noc_out_data),
        .out_count(out_count), .err_oversize(err_oversize), .err_bad_tile(err_bad_tile)
    );

    always #5 clk = ~clk;

    // Reference header: plain shifts of the field values.
    function automatic logic [63:0] ref_hdr(input int y, input int x, input int len, input int typ);
        return (64'(y) << 56) | (64'(x) << 48) | (64'(len) << 22) | (64'(typ) << 14);
    endfunction

    function automatic logic [63:0] ref_intr_flit0(input int tile);
        return ref_hdr(tile / 8, tile % 8, 1, int'(noc_iob_bridge_pkg::MSG_TYPE_INTERRUPT));
    endfunction

    function automatic logic [63:0] ref_intr_flit1(input logic [63:0] d);
        return d & 64'hFFFF_FFFF_FFFF_01FF;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Random header flit carrying the given body length.
    function automatic logic [63:0] rand_hdr(input int len);
        logic [63:0] h;
        h = rand64();
        h[29:22] = 8'(len);
        return h;
    endfunction

    // Expected request image: first min(n,4) flits, header on top, rest zero.
    function automatic logic [4*FW-1:0] ref_req(input logic [63:0] f [8], input int n);
        logic [4*FW-1:0] r;
        r = '0;
        for (int i = 0; i < 4 && i < n; i++) r[(3-i)*FW +: FW] = f[i];
        return r;
    endfunction

    task automatic send_flit(input logic [63:0] d);
        logic acc, ok;
        noc_in_val = 1'b1; noc_in_data = d; ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            acc = noc_in_rdy;
            @(negedge clk);
            if (acc) begin ok = 1'b1; break; end
        end
        noc_in_val = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL flit_accept: accepted=%0b required=1", ok); end
    endtask

    task automatic send_intr(input logic [31:0] tile, input logic [63:0] d);
        logic acc, ok;
        intr_val = 1'b1; intr_tile = tile; intr_data = d; ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            acc = intr_rdy;
            @(negedge clk);
            if (acc) begin ok = 1'b1; break; end
        end
        intr_val = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL intr_accept: accepted=%0b required=1", ok); end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        noc_in_val = 1'b1; noc_in_data = rand64(); req_rdy = 1'b0;
        intr_val = 1'b1; intr_tile = 32'd3; intr_data = rand64(); noc_out_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (noc_in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy: got %b want 1", noc_in_rdy); end
        checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL rst_req_val: got %b want 0", req_val); end
        checks++; if (noc_out_val !== 1'b0) begin errors++; $display("FAIL rst_out_val: got %b want 0", noc_out_val); end
        checks++; if (intr_rdy !== 1'b1) begin errors++; $display("FAIL rst_intr_rdy: got %b want 1", intr_rdy); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", out_count); end
        checks++; if ({err_oversize, err_bad_tile} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b want 00", {err_oversize, err_bad_tile}); end
        noc_in_val = 1'b0; intr_val = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (noc_out_val !== 1'b0 || req_val !== 1'b0) begin errors++; $display("FAIL post_rst_idle: out_val=%b req_val=%b want 0 0", noc_out_val, req_val); end
    endtask

    task automatic test_inbound_3flit();
        logic [63:0] f [8];
        f[0] = rand_hdr(2); f[1] = rand64(); f[2] = rand64();
        req_rdy = 1'b1;
        for (int i = 0; i < 3; i++) send_flit(f[i]);
        checks++; if (req_val !== 1'b1) begin errors++; $display("FAIL p3_req_val: got %b want 1", req_val); end
        checks++; if (req_len !== 3'd3) begin errors++; $display("FAIL p3_req_len: got %0d want 3", req_len); end
        checks++; if (req_data !== ref_req(f, 3)) begin errors++; $display("FAIL p3_req_data: got %h want %h", req_data, ref_req(f, 3)); end
        checks++; if (noc_in_rdy !== 1'b0) begin errors++; $display("FAIL p3_rdy_low: got %b want 0", noc_in_rdy); end
        @(negedge clk);
        checks++; if (noc_in_rdy !== 1'b1 || req_val !== 1'b0) begin errors++; $display("FAIL p3_after: rdy=%b req_val=%b want 1 0", noc_in_rdy, req_val); end
        req_rdy = 1'b0;
    endtask

    task automatic test_oversize();
        logic [63:0] f [8];
        f[0] = rand_hdr(6);
        for (int i = 1; i < 7; i++) f[i] = rand64();
        req_rdy = 1'b0;
        for (int i = 0; i < 7; i++) send_flit(f[i]);
        checks++; if (req_val !== 1'b1) begin errors++; $display("FAIL ovs_req_val: got %b want 1", req_val); end
        checks++; if (req_len !== 3'd4) begin errors++; $display("FAIL ovs_req_len: got %0d want 4", req_len); end
        checks++; if (req_data !== ref_req(f, 4)) begin errors++; $display("FAIL ovs_req_data: got %h want %h", req_data, ref_req(f, 4)); end
        checks++; if (err_oversize !== 1'b1) begin errors++; $display("FAIL ovs_flag: got %b want 1", err_oversize); end
        req_rdy = 1'b1;
        @(negedge clk);
        req_rdy = 1'b0;
        checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL ovs_release: got %b want 0", req_val); end
    endtask

    task automatic test_intr_tile19();
        logic [63:0] d;
        d = rand64() | 64'h0000_0000_0000_FE00;
        noc_out_rdy = 1'b0;
        send_intr(32'd19, d);
        checks++; if (noc_out_val !== 1'b1) begin errors++; $display("FAIL t19_latency: out_val=%b want 1", noc_out_val); end
        checks++; if (out_count !== 4'd2) begin errors++; $display("FAIL t19_count: got %0d want 2", out_count); end
        checks++; if (noc_out_data !== ref_intr_flit0(19)) begin errors++; $display("FAIL t19_flit1: got %h want %h", noc_out_data, ref_intr_flit0(19)); end
        noc_out_rdy = 1'b1;
        @(negedge clk);
        checks++; if (noc_out_data !== ref_intr_flit1(d) || noc_out_data[15:9] !== 7'd0) begin errors++; $display("FAIL t19_flit2: got %h want %h", noc_out_data, ref_intr_flit1(d)); end
        @(negedge clk);
        noc_out_rdy = 1'b0;
        checks++; if (out_count !== 4'd0 || noc_out_val !== 1'b0 || noc_out_data !== 64'd0) begin errors++; $display("FAIL t19_drain: count=%0d val=%b data=%h want 0 0 0", out_count, noc_out_val, noc_out_data); end
    endtask

    task automatic test_bad_tile();
        send_intr(32'd64, rand64());
        checks++; if (out_count !== 4'd0 || noc_out_val !== 1'b0) begin errors++; $display("FAIL bad_tile_push: count=%0d val=%b want 0 0", out_count, noc_out_val); end
        checks++; if (err_bad_tile !== 1'b1) begin errors++; $display("FAIL bad_tile_flag: got %b want 1", err_bad_tile); end
    endtask

    task automatic test_fifo_full();
        int acc;
        acc = 0;
        noc_out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            intr_val = 1'b1; intr_tile = 32'($urandom_range(0, 63)); intr_data = rand64();
            if (intr_rdy) acc++;
            @(negedge clk);
        end
        intr_val = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL full_accepts: got %0d want 4", acc); end
        checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", out_count); end
        checks++; if (intr_rdy !== 1'b0) begin errors++; $display("FAIL full_intr_rdy: got %b want 0", intr_rdy); end
        noc_out_rdy = 1'b1;
        @(negedge clk);
        noc_out_rdy = 1'b0;
        checks++; if (out_count !== 4'd7) begin errors++; $display("FAIL full_pop1: got %0d want 7", out_count); end
        checks++; if (intr_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy7: got %b want 0", intr_rdy); end
        noc_out_rdy = 1'b1;
        repeat (7) @(negedge clk);
        noc_out_rdy = 1'b0;
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", out_count); end
    endtask

    task automatic test_reset_midpacket();
        logic [63:0] f [8];
        req_rdy = 1'b0;
        send_flit(rand_hdr(3));
        send_flit(rand64());
        noc_in_val = 1'b1; noc_in_data = rand64();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; noc_in_val = 1'b0;
        checks++; if (req_val !== 1'b0 || noc_in_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: req_val=%b rdy=%b want 0 1", req_val, noc_in_rdy); end
        checks++; if ({err_oversize, err_bad_tile} !== 2'b00) begin errors++; $display("FAIL mid_rst_errs: got %b want 00", {err_oversize, err_bad_tile}); end
        f[0] = rand_hdr(0);
        send_flit(f[0]);
        checks++; if (req_val !== 1'b1 || req_len !== 3'd1) begin errors++; $display("FAIL mid_rst_pkt: req_val=%b len=%0d want 1 1", req_val, req_len); end
        checks++; if (req_data !== ref_req(f, 1)) begin errors++; $display("FAIL mid_rst_data: got %h want %h", req_data, ref_req(f, 1)); end
        req_rdy = 1'b1;
        @(negedge clk);
        req_rdy = 1'b0;
    endtask

    task automatic test_random_pkt();
        logic [63:0] f [8];
        logic ovs;
        int len, n, w;
        ovs = 1'b0;
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(0, 6);
            n = len + 1;
            f[0] = rand_hdr(len);
            for (int i = 1; i < n; i++) f[i] = rand64();
            if (len > 3) ovs = 1'b1;
            req_rdy = 1'b0;
            for (int i = 0; i < n; i++) begin
                w = $urandom_range(0, 2);
                repeat (w) @(negedge clk);
                send_flit(f[i]);
            end
            w = $urandom_range(0, 2);
            repeat (w) @(negedge clk);
            checks++; if (req_val !== 1'b1) begin errors++; $display("FAIL rp_req_val: pkt %0d got %b want 1", p, req_val); end
            checks++; if (int'(req_len) != (n > 4 ? 4 : n)) begin errors++; $display("FAIL rp_req_len: pkt %0d got %0d want %0d", p, req_len, (n > 4 ? 4 : n)); end
            checks++; if (req_data !== ref_req(f, n)) begin errors++; $display("FAIL rp_req_data: pkt %0d got %h want %h", p, req_data, ref_req(f, n)); end
            checks++; if (err_oversize !== ovs) begin errors++; $display("FAIL rp_oversize: pkt %0d got %b want %b", p, err_oversize, ovs); end
            req_rdy = 1'b1;
            @(negedge clk);
            req_rdy = 1'b0;
            checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL rp_release: pkt %0d got %b want 0", p, req_val); end
        end
    endtask

    task automatic test_random_intr();
        logic [63:0] q [$];
        logic bad, exp_rdy, pop_n, val_n;
        int tile;
        logic [63:0] d;
        bad = 1'b0;
        for (int c = 0; c < 300; c++) begin
            exp_rdy = (8 - q.size()) >= 2;
            checks++; if (int'(out_count) != q.size()) begin errors++; $display("FAIL ri_count: cyc %0d got %0d want %0d", c, out_count, q.size()); end
            checks++; if (noc_out_val !== (q.size() != 0)) begin errors++; $display("FAIL ri_val: cyc %0d got %b want %b", c, noc_out_val, (q.size() != 0)); end
            if (q.size() != 0) begin
                checks++; if (noc_out_data !== q[0]) begin errors++; $display("FAIL ri_data: cyc %0d got %h want %h", c, noc_out_data, q[0]); end
            end
            checks++; if (intr_rdy !== exp_rdy) begin errors++; $display("FAIL ri_intr_rdy: cyc %0d got %b want %b", c, intr_rdy, exp_rdy); end
            checks++; if (err_bad_tile !== bad) begin errors++; $display("FAIL ri_bad_flag: cyc %0d got %b want %b", c, err_bad_tile, bad); end
            pop_n = $urandom_range(0, 3) != 0;
            val_n = $urandom_range(0, 1) != 0;
            tile  = $urandom_range(0, 70);
            d     = rand64();
            noc_out_rdy = pop_n; intr_val = val_n; intr_tile = 32'(tile); intr_data = d;
            if (pop_n && q.size() != 0) void'(q.pop_front());
            if (val_n && exp_rdy) begin
                if (tile < 64) begin
                    q.push_back(ref_intr_flit0(tile));
                    q.push_back(ref_intr_flit1(d));
                end else bad = 1'b1;
            end
            @(negedge clk);
        end
        intr_val = 1'b0; noc_out_rdy = 1'b1;
        repeat (10) @(negedge clk);
        noc_out_rdy = 1'b0;
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL ri_final_drain: got %0d want 0", out_count); end
    endtask

    initial begin
        rst_n = 1'b0; noc_in_val = 1'b0; noc_in_data = '0; req_rdy = 1'b0;
        intr_val = 1'b0; intr_tile = '0; intr_data = '0; noc_out_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_inbound_3flit();
        test_oversize();
        test_intr_tile19();
        test_bad_tile();
        test_fifo_full();
        test_reset_midpacket();
        test_random_pkt();
        apply_reset();
        test_random_intr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
